data_memory_hs: RTL and testbench
=================================

Name: data_memory_hs

Overview:
- Parametrised successor to the single-cycle data memory: byte-addressed, byte-lane-masked load/store memory with a valid/ready request channel and a configurable read latency.
- Sits between the datapath's load/store unit and storage in the pipelined/multi-cycle core.
- Supports byte/half/word(/double) accesses with sign or zero extension.
- Locations never written since reset always read as zero.

Parameters:
- WL, 32, data word width in bits; legal values 32 or 64.
- DEPTH, 256, number of WL-bit words.
- ADDR_W, 32, width of byte address A.
- RD_LAT, 1, cycles from read acceptance to rsp_valid; legal range 1..8.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RST  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word(32b), 11 double(64b; legal only when WL=64).
- req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
- A  input  ADDR_W  byte address.
- WD  input  WL  store data, right-aligned (LSBs hold the data).
- rsp_valid  output  1  one-cycle pulse: load data or store acknowledge.
- RD  output  WL  load result, right-aligned and extended; 0 on store ack or error.
- rsp_err  output  1  qualified by rsp_valid; out-of-range (or misaligned, see option).

Behaviour:
- Reset values: req_ready=1, rsp_valid=0, RD=0, rsp_err=0, FSM=IDLE, latency counter=0.
- Reset also clears every per-byte written flag (DEPTH*WL/8 flags). All contents then read as 0.
- Byte lanes: NB=WL/8. Word index = A[ADDR_W-1:log2(NB)]. Lane offset = A[log2(NB)-1:0].
- Access size: 1, 2, 4 or 8 bytes.
- Acceptance: a request is accepted when req_valid && req_ready at a posedge. All request fields are captured at that edge.
- Out of range: word index >= DEPTH.
  - Store is suppressed.
  - Load returns RD=0.
  - rsp_err=1 on the response.
- Illegal size: req_size=11 with WL=32 is treated as error. No write; RD=0; rsp_err=1.
- FSM states: IDLE, RD_WAIT, RESP.
  - IDLE: req_ready=1.
    - Accepted store: selected bytes written at the acceptance edge and their written flags set. Go to RESP.
    - Accepted load: storage and written flags are sampled at the acceptance edge. Counter loaded with RD_LAT-1. Go to RESP if RD_LAT=1, else RD_WAIT.
  - RD_WAIT: req_ready=0. Counter decrements each cycle. Go to RESP when it reaches 1.
  - RESP: req_ready=0, rsp_valid=1 for exactly one cycle, then IDLE.
- Latency: load rsp_valid is asserted RD_LAT cycles after the acceptance edge. Store ack is asserted 1 cycle after acceptance.
- Throughput: maximum one transaction per (RD_LAT+1) cycles for loads, per 2 cycles for stores.
- Load result:
  - Bytes with a clear written flag contribute 0x00.
  - Selected bytes are shifted to the LSBs, then sign- or zero-extended to WL.
- Store: only lanes [offset .. offset+size-1] are modified. Other bytes and their flags are unchanged.
- Stability: RD and rsp_err hold their last response values while rsp_valid=0. Nothing downstream may rely on this.
- Reset mid-operation: RST dominates at any state.
  - A pending load is dropped; no response is issued.
  - FSM returns to IDLE and outputs take reset values on the next edge.
  - A store accepted in the same cycle as RST is not performed.
- req_valid while req_ready=0 is ignored. The requester must hold the request until accepted.

Optional Feature:
- Macro DMEM_ALIGN_CHK_EN.
- Defined: an access whose lane offset is not a multiple of its size is flagged misaligned. No write occurs; load RD=0; rsp_err=1. Response timing is unchanged.
- Undefined: offset bits below the access size are forced to 0 (address silently aligned down), and no misalignment error is reported.
- Out-of-range and illegal-size errors are reported in both builds.

Test Plan:
- Reset, then load word A=0x10 -> rsp_valid after RD_LAT cycles, RD=0x00000000, rsp_err=0.
- Store word 0x8000_00F0 at A=0x20, then load byte unsigned A=0x20 -> RD=0x000000F0.
  - Load byte signed A=0x23 -> RD=0xFFFFFF80.
  - Load half signed A=0x22 -> RD=0xFFFF8000.
- Store byte 0xAB at A=0x41 only, then load word A=0x40 -> RD=0x0000AB00 (unwritten bytes read 0).
- RD_LAT=4: load issued -> req_ready low 4 cycles, rsp_valid exactly at cycle 4. Second req_valid held during wait is accepted only on the cycle after rsp_valid.
- DEPTH=256, WL=32: store to A=0x400 -> ack with rsp_err=1; subsequent load A=0x0 returns 0. With DMEM_ALIGN_CHK_EN: load half A=0x21 -> rsp_err=1, RD=0. Without it: same access reads half at 0x20.
- Store word at 0x30, then assert RST during a subsequent RD_LAT=3 load -> no rsp_valid. Load 0x30 after reset returns 0.

Source files
------------

// File: rtl/data_memory_hs.sv
// Byte-addressed load/store data memory with a valid/ready request channel and RD_LAT-cycle reads.
// Optional macro DMEM_ALIGN_CHK_EN: misaligned accesses become errors instead of being aligned down.
module data_memory_hs #(
    parameter int WL     = 32,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] A,
    input  logic [WL-1:0]     WD,
    output logic              rsp_valid,
    output logic [WL-1:0]     RD,
    output logic              rsp_err
);
    localparam int NB     = WL / 8;
    localparam int OFF_W  = $clog2(NB);
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WIDX_W = ADDR_W - OFF_W;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;
    state_t state, next_state;

    logic [WL-1:0] mem     [DEPTH];
    logic [NB-1:0] written [DEPTH];

    logic [CNT_W-1:0]  cnt;
    logic [WL-1:0]     pend_data;
    logic              pend_err;

    logic              accept, store_en;
    logic [WIDX_W-1:0] word_idx;
    logic [IDX_W-1:0]  mem_idx;
    logic [OFF_W-1:0]  raw_off, size_mask, eff_off;
    logic [1:0]        size_cl;
    logic              size_err, range_err, align_err, acc_err, sign_bit;
    int                nbytes;
    logic [NB-1:0]     lane_sel;
    logic [WL-1:0]     stored, rd_shift, keep, load_val, acc_data, wr_data;

    always_comb begin
        word_idx  = A[ADDR_W-1:OFF_W];
        mem_idx   = word_idx[IDX_W-1:0];
        raw_off   = A[OFF_W-1:0];
        size_err  = (req_size == 2'b11) && (WL == 32);
        size_cl   = size_err ? 2'b10 : req_size;
        nbytes    = 1 << size_cl;
        size_mask = OFF_W'(nbytes - 1);
        range_err = word_idx >= WIDX_W'(DEPTH);
`ifdef DMEM_ALIGN_CHK_EN
        align_err = (raw_off & size_mask) != '0;
        eff_off   = raw_off;
`else
        align_err = 1'b0;
        eff_off   = raw_off & ~size_mask;
`endif
        acc_err   = size_err || range_err || align_err;
    end

    // Never-written bytes are masked to zero before the selected bytes are extracted
    always_comb begin
        stored = '0;
        if (!range_err) begin
            for (int b = 0; b < NB; b++)
                stored[8*b +: 8] = written[mem_idx][b] ? mem[mem_idx][8*b +: 8] : 8'h00;
        end
        rd_shift = stored >> {eff_off, 3'b000};
        case (size_cl)
            2'd0:    sign_bit = rd_shift[7];
            2'd1:    sign_bit = rd_shift[15];
            2'd2:    sign_bit = rd_shift[31];
            default: sign_bit = rd_shift[WL-1];
        endcase
        for (int i = 0; i < WL; i++)
            keep[i] = (i < 8 * nbytes);
        load_val = (rd_shift & keep) | (~keep & {WL{sign_bit && !req_unsigned}});
        acc_data = (req_we || acc_err) ? '0 : load_val;
    end

    always_comb begin
        wr_data = WD << {eff_off, 3'b000};
        for (int b = 0; b < NB; b++)
            lane_sel[b] = (b >= int'(eff_off)) && (b < int'(eff_off) + nbytes);
    end

    assign accept   = req_valid && req_ready;
    assign store_en = accept && req_we && !acc_err && !RST;

    always_ff @(posedge CLK) begin
        if (store_en) begin
            for (int b = 0; b < NB; b++)
                if (lane_sel[b]) mem[mem_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++)
                written[i] <= '0;
        end else if (store_en) begin
            written[mem_idx] <= written[mem_idx] | lane_sel;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = (req_we || RD_LAT == 1) ? RESP : RD_WAIT;
            RD_WAIT: if (cnt == CNT_W'(1)) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == RESP);
    end

    // Response registers only change when entering RESP, so RD/rsp_err hold between responses
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt       <= '0;
            pend_data <= '0;
            pend_err  <= 1'b0;
            RD        <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (state == IDLE && accept) begin
                cnt       <= CNT_W'(RD_LAT - 1);
                pend_data <= acc_data;
                pend_err  <= acc_err;
            end else if (state == RD_WAIT) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (next_state == RESP) begin
                RD      <= (state == IDLE) ? acc_data : pend_data;
                rsp_err <= (state == IDLE) ? acc_err  : pend_err;
            end
        end
    end
endmodule

// File: tb/tb_data_memory_hs.sv
// Bench for data_memory_hs: two instances (RD_LAT=1 and RD_LAT=4) share one request stream,
// with per-instance expected-response queues popped whenever rsp_valid pulses.
module tb_data_memory_hs;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        valid1 = 1'b0, valid4 = 1'b0;
    logic        req_we = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] A = '0, WD = '0;
    logic        ready1, rsp1, err1, ready4, rsp4, err4;
    logic [31:0] rd1, rd4;
    int          checks = 0;
    int          failures = 0;

    typedef struct packed {
        logic [31:0] rd;
        logic        err;
    } exp_t;
    exp_t q1[$];
    exp_t q4[$];

    always #5 CLK = ~CLK;

    data_memory_hs #(.WL(32), .DEPTH(256), .ADDR_W(32), .RD_LAT(1)) dut1 (
        .CLK(CLK), .RST(RST), .req_valid(valid1), .req_ready(ready1), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .A(A), .WD(WD),
        .rsp_valid(rsp1), .RD(rd1), .rsp_err(err1)
    );

    data_memory_hs #(.WL(32), .DEPTH(256), .ADDR_W(32), .RD_LAT(4)) dut4 (
        .CLK(CLK), .RST(RST), .req_valid(valid4), .req_ready(ready4), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .A(A), .WD(WD),
        .rsp_valid(rsp4), .RD(rd4), .rsp_err(err4)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (rsp1 === 1'b1) begin
            checkOutput("dut1 rsp expected", 32'(q1.size() != 0), 32'd1);
            if (q1.size() != 0) begin
                e = q1.pop_front();
                checkOutput("dut1 RD", rd1, e.rd);
                checkOutput("dut1 rsp_err", 32'(err1), 32'(e.err));
            end
        end
    end

    always @(negedge CLK) begin
        exp_t e;
        if (rsp4 === 1'b1) begin
            checkOutput("dut4 rsp expected", 32'(q4.size() != 0), 32'd1);
            if (q4.size() != 0) begin
                e = q4.pop_front();
                checkOutput("dut4 RD", rd4, e.rd);
                checkOutput("dut4 rsp_err", 32'(err4), 32'(e.err));
            end
        end
    end

    task automatic waitIdle();
        int n;
        n = 0;
        while ((q1.size() != 0 || q4.size() != 0) && n < 40) begin
            @(posedge CLK);
            n++;
        end
        checkOutput("drain", 32'(q1.size() + q4.size()), 32'd0);
        q1.delete();
        q4.delete();
    endtask

    task automatic pushExp(input logic to1, input logic to4, input logic [31:0] rd, input logic err);
        exp_t e;
        e.rd  = rd;
        e.err = err;
        if (to1) q1.push_back(e);
        if (to4) q4.push_back(e);
    endtask

    // Drives one request to both instances and holds it until each has accepted it
    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] exp_rd, input logic exp_err);
        int   n;
        logic a1, a4;
        waitIdle();
        @(negedge CLK);
        req_we = we; req_size = size; req_unsigned = uns; A = addr; WD = wdata;
        valid1 = 1'b1; valid4 = 1'b1;
        pushExp(1'b1, 1'b1, exp_rd, exp_err);
        n = 0;
        while ((valid1 || valid4) && n < 20) begin
            a1 = valid1 && ready1;
            a4 = valid4 && ready4;
            @(posedge CLK); #1;
            if (a1) valid1 = 1'b0;
            if (a4) valid4 = 1'b0;
            n++;
        end
        checkOutput("accept", {30'b0, valid1, valid4}, 32'd0);
        valid1 = 1'b0; valid4 = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int seen;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        checkOutput("reset ready1", 32'(ready1), 32'd1);
        checkOutput("reset ready4", 32'(ready4), 32'd1);
        checkOutput("reset rsp1", 32'(rsp1), 32'd0);
        checkOutput("reset rsp4", 32'(rsp4), 32'd0);
        checkOutput("reset RD1", rd1, 32'd0);
        checkOutput("reset err1", 32'(err1), 32'd0);

        applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0);
        @(negedge CLK);
        checkOutput("dut1 load latency", 32'(rsp1), 32'd1);
        checkOutput("dut4 still waiting", 32'(ready4), 32'd0);

        applyStimulus(1'b1, 2'b10, 1'b0, 32'h20, 32'h8000_00F0, 32'h0, 1'b0);
        @(negedge CLK);
        checkOutput("dut1 store ack latency", 32'(rsp1), 32'd1);
        checkOutput("dut4 store ack latency", 32'(rsp4), 32'd1);

        applyStimulus(1'b0, 2'b00, 1'b1, 32'h20, 32'h0, 32'h0000_00F0, 1'b0);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h23, 32'h0, 32'hFFFF_FF80, 1'b0);
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 32'hFFFF_8000, 1'b0);
        applyStimulus(1'b1, 2'b00, 1'b0, 32'h41, 32'h0000_00AB, 32'h0, 1'b0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h0000_AB00, 1'b0);
        applyStimulus(1'b0, 2'b01, 1'b1, 32'h20, 32'h0, 32'h0000_00F0, 1'b0);
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h40, 32'h0, 32'hFFFF_AB00, 1'b0);

        // Out-of-range and illegal-size requests; word 0 must stay unwritten
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h400, 32'hCAFE_BABE, 32'h0, 1'b1);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1);
        applyStimulus(1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 32'h0, 1'b1);
        applyStimulus(1'b1, 2'b11, 1'b0, 32'h0, 32'hFFFF_FFFF, 32'h0, 1'b1);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);

`ifdef DMEM_ALIGN_CHK_EN
        applyStimulus(1'b0, 2'b01, 1'b1, 32'h21, 32'h0, 32'h0, 1'b1);
        applyStimulus(1'b1, 2'b01, 1'b0, 32'h41, 32'h0000_1234, 32'h0, 1'b1);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h0000_AB00, 1'b0);
`else
        applyStimulus(1'b0, 2'b01, 1'b1, 32'h21, 32'h0, 32'h0000_00F0, 1'b0);
        applyStimulus(1'b1, 2'b01, 1'b0, 32'h41, 32'h0000_1234, 32'h0, 1'b0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h0000_1234, 1'b0);
`endif

        // RD_LAT=4 instance: busy for four cycles, held second request taken right after rsp_valid
        waitIdle();
        @(negedge CLK);
        req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; A = 32'h20; WD = '0;
        valid4 = 1'b1;
        pushExp(1'b0, 1'b1, 32'h8000_00F0, 1'b0);
        checkOutput("lat ready before", 32'(ready4), 32'd1);
        @(posedge CLK); #1;
        req_size = 2'b00; req_unsigned = 1'b1; A = 32'h23;
        pushExp(1'b0, 1'b1, 32'h0000_0080, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge CLK);
            checkOutput("lat ready low", 32'(ready4), 32'd0);
            checkOutput("lat rsp_valid", 32'(rsp4), 32'(k == 4));
        end
        @(negedge CLK);
        checkOutput("lat second accept", 32'(ready4), 32'd1);
        @(posedge CLK); #1;
        valid4 = 1'b0;
        @(negedge CLK);
        checkOutput("lat busy again", 32'(ready4), 32'd0);

        applyStimulus(1'b1, 2'b10, 1'b0, 32'h30, 32'h1122_3344, 32'h0, 1'b0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 32'h1122_3344, 1'b0);

        // Reset in the middle of a pending RD_LAT=4 load drops it
        waitIdle();
        @(negedge CLK);
        req_we = 1'b0; req_size = 2'b10; A = 32'h30;
        valid4 = 1'b1;
        @(posedge CLK); #1;
        valid4 = 1'b0;
        @(negedge CLK);
        checkOutput("rst pending busy", 32'(ready4), 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        checkOutput("rst ready4", 32'(ready4), 32'd1);
        checkOutput("rst RD4", rd4, 32'd0);
        seen = 0;
        repeat (8) begin
            @(negedge CLK);
            if (rsp4 === 1'b1) seen++;
        end
        checkOutput("rst no response", 32'(seen), 32'd0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 32'h0, 1'b0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0);

        // A store coinciding with reset is not performed
        waitIdle();
        @(negedge CLK);
        RST = 1'b1; req_we = 1'b1; req_size = 2'b10; A = 32'h50; WD = 32'hDEAD_BEEF;
        valid1 = 1'b1; valid4 = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0; valid1 = 1'b0; valid4 = 1'b0;
        @(negedge CLK);
        checkOutput("rst store no ack", 32'(rsp1), 32'd0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h50, 32'h0, 32'h0, 1'b0);

        waitIdle();
        repeat (2) @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
